rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Shares the register file's single write port between NUM_REQ writeback sources (req 0 = ALU/EX, req 1 = MEM load).
//  Each source has its own small FIFO; a round-robin arbiter drains the FIFO heads into the write port, one write per cycle.
//  Also exports a per-register pending-write vector that hazard/stall logic uses.
//  Sits between the writeback stage and the register file write port.
// PARAMETERS
//  NUM_REQ     2   number of write requesters (>=2)
//  DATA_W      16  register data width
//  REG_ID_W    4   register id width; NUM_REGS = 2**REG_ID_W
//  FIFO_DEPTH  2   entries per requester FIFO (power of 2, >=2)
// PORTS
//  clk          in   1                  clock, all state on rising edge
//  rst          in   1                  asynchronous, active-high reset
//  req_valid    in   NUM_REQ            requester i presents a write
//  req_ready    out  NUM_REQ            requester i FIFO can accept
//  req_reg_id   in   NUM_REQ*REG_ID_W   destination register, slice i
//  req_data     in   NUM_REQ*DATA_W     write data, slice i
//  wr_en        out  1                  register file write enable (registered)
//  wr_reg_id    out  REG_ID_W           register file write address (registered)
//  wr_data      out  DATA_W             register file write data (registered)
//  wr_grant     out  NUM_REQ            one-hot source of current write (registered)
//  busy         out  NUM_REGS           busy[r]=1: a queued or in-flight write targets r
// BEHAVIOUR
//  Reset: all FIFOs empty; wr_en=0, wr_reg_id=0, wr_data=0, wr_grant=0; RR pointer = NUM_REQ-1, so req 0 wins first; busy=0.
//  Accept: on a rising edge with req_valid[i]&req_ready[i], the entry is pushed into FIFO i.
//  req_ready[i] = ~full[i]. It depends only on FIFO state, with no combinational path from req_valid. A full FIFO does not accept, even if it pops in the same cycle.
//  Register 0 writes: accepted normally and drained in order. When drained, wr_en stays 0 for that slot; the slot still consumes the grant.
//  Arbitration is combinational over non-empty FIFO heads. Search order starts at last_grant+1 and wraps modulo NUM_REQ.
//   The winner pops at the edge, and last_grant updates to it.
//   If no FIFO is non-empty, nothing pops and the pointer holds.
//  Output register at the same edge: wr_en=(reg_id!=0), wr_reg_id/wr_data=head, wr_grant=onehot(winner).
//   With no winner: wr_en=0, wr_grant=0; wr_reg_id/wr_data hold their last value.
//  Latency: an entry pushed at edge E (FIFO empty, no competitor) is visible on wr_* from edge E+1 and is written by the RF at edge E+2.
//   There is no bypass from req_* straight to wr_*.
//  Throughput: one write per cycle total. With all FIFOs continuously non-empty, grants strictly alternate (fair).
//  Simultaneous push and pop on the same FIFO in one edge is legal (non-full case); the count is unchanged.
//  Ordering: FIFO order is preserved within a requester. Across requesters, order is arbitration order only.
//   The pipeline must not issue same-register writes from two sources in flight; busy exists to enforce this.
//  busy[r] = OR over valid FIFO entries of onehot(reg_id), plus onehot(wr_reg_id) when wr_en=1. busy[0] is always 0.
//   busy is combinational from state only.
//  Push with req_valid high and req_ready low: no state change. The requester must hold data stable (valid/ready protocol).
//  Reset asserted mid-operation: all queued writes are discarded immediately (asynchronous) and every output returns to its reset value.
// STRUCTURE
//  Shared package rf_pkg: DATA_W, REG_ID_W, NUM_REGS, ZERO_REG=0, function onehot_reg(id)->NUM_REGS.
//  Sub-module rf_wr_fifo: one instance per requester.
//   Ports: clk, rst, push, pop, din{reg_id,data}, dout, empty, full, plus per-entry valid/reg_id taps for busy.
//   Implemented as a circular buffer with wrapping rd/wr pointers and a count.
//  Top level: generate loop of FIFOs, rotate-priority RR arbiter, output register, busy OR-tree.
// TESTING
//  1 Reset, then req0 valid reg=3 data=16'hABCD, one cycle.
//    -> wr_en=1, wr_reg_id=3, wr_data=ABCD, wr_grant=01 one cycle later; busy[3]=1 from push until wr_en drops.
//  2 Both valid every cycle: req0 reg 1..4, req1 reg 5..8, data=reg*16'h1111.
//    -> writes in order 1,5,2,6,3,7,4,8; wr_en high on 8 consecutive cycles; ready honoured.
//  3 req1 held valid, nothing drained beyond the first pop; FIFO_DEPTH=2; req0 streams continuously.
//    -> req1 is never starved: each requester is granted at least every 2nd cycle.
//    -> req_ready[1]=0 exactly when its count=2.
//  4 req0 writes reg 0 (data 16'hFFFF), then reg 2 (data 16'h0005).
//    -> slot 1 has wr_en=0 and wr_grant=01; slot 2 has wr_en=1, reg 2, data 5; busy[0] is never set.
//  5 Fill both FIFOs (4 entries), then assert rst for 1 cycle mid-drain.
//    -> next cycle wr_en=0, busy=0, req_ready=11; after release, the first grant goes to req0.
//  6 Push to a full FIFO while it pops in the same edge.
//    -> the push is refused (req_ready=0 that cycle); no entry is lost or duplicated (check with a scoreboard).

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types for the register-file write arbiter.
// Widths, entry struct and a one-hot register decode helper.
package rf_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_ID_W = 4;
    localparam int NUM_REGS = 1 << REG_ID_W;
    localparam int ZERO_REG = 0;

    typedef logic [REG_ID_W-1:0] reg_id_t;
    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [NUM_REGS-1:0] reg_vec_t;

    typedef struct packed {
        reg_id_t reg_id;
        data_t   data;
    } wr_entry_t;

    // Register 0 is never written, so it never shows as busy.
    function automatic reg_vec_t onehot_reg(input reg_id_t id);
        reg_vec_t v;
        v = '0;
        if (id != reg_id_t'(ZERO_REG)) begin
            v[id] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback request / register-file write bundle.
// master: requesters + RF side; slave: the arbiter.
interface rf_write_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import rf_pkg::*;

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*REG_ID_W-1:0] req_reg_id;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic                        wr_en;
    reg_id_t                     wr_reg_id;
    data_t                       wr_data;
    logic [NUM_REQ-1:0]          wr_grant;
    reg_vec_t                    busy;

    modport master (
        output req_valid, req_reg_id, req_data,
        input  req_ready, wr_en, wr_reg_id, wr_data,
        input  wr_grant, busy
    );

    modport slave (
        input  req_valid, req_reg_id, req_data,
        output req_ready, wr_en, wr_reg_id, wr_data,
        output wr_grant, busy
    );

endinterface

// File: rtl/rf_wr_fifo.sv
// Per-requester circular-buffer FIFO of pending RF writes.
// Ports: push/pop/din/dout/empty/full plus per-entry valid/reg_id taps.
module rf_wr_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  wr_entry_t             din,
    output wr_entry_t             dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH-1:0]      ent_valid,
    output reg_id_t [DEPTH-1:0]   ent_reg_id
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wr_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // An entry is live when its distance from the read pointer
    // is below the occupancy count.
    always_comb begin
        logic [PW-1:0] off;
        off = '0;
        for (int k = 0; k < DEPTH; k++) begin
            off           = PW'(k) - rd_ptr;
            ent_valid[k]  = (CW'(off) < count);
            ent_reg_id[k] = mem[k].reg_id;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the RF write port among NUM_REQ FIFOs.
// Ports: clk, rst, bus (slave) carrying req_*, wr_* and busy.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    rf_write_arbiter_if.slave   bus
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    wr_entry_t [NUM_REQ-1:0]                 din;
    wr_entry_t [NUM_REQ-1:0]                 head;
    logic [NUM_REQ-1:0]                      empty;
    logic [NUM_REQ-1:0]                      full;
    logic [NUM_REQ-1:0]                      push;
    logic [NUM_REQ-1:0]                      pop;
    logic [NUM_REQ-1:0][FIFO_DEPTH-1:0]      ent_vld;
    reg_id_t [NUM_REQ-1:0][FIFO_DEPTH-1:0]   ent_id;

    logic               win_found;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      last_grant;

    logic               wr_en_q;
    reg_id_t            wr_reg_id_q;
    data_t              wr_data_q;
    logic [NUM_REQ-1:0] wr_grant_q;
    reg_vec_t           busy_c;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
        assign din[g].reg_id = bus.req_reg_id[g*REG_ID_W +: REG_ID_W];
        assign din[g].data   = bus.req_data[g*DATA_W +: DATA_W];
        assign push[g]       = bus.req_valid[g] & ~full[g];
        assign pop[g]        = win_found & (win_idx == IW'(g));

        rf_wr_fifo #(
            .DEPTH      (FIFO_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push       (push[g]),
            .pop        (pop[g]),
            .din        (din[g]),
            .dout       (head[g]),
            .empty      (empty[g]),
            .full       (full[g]),
            .ent_valid  (ent_vld[g]),
            .ent_reg_id (ent_id[g])
        );
    end

    // Ready comes from FIFO state only, so a full FIFO refuses
    // even when it pops on the same edge.
    assign bus.req_ready = ~full;

    // Search starts one past the last winner and wraps.
    always_comb begin
        int c;
        c         = 0;
        win_found = 1'b0;
        win_idx   = last_grant;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = int'(last_grant) + k;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            if (!win_found && !empty[c]) begin
                win_found = 1'b1;
                win_idx   = IW'(c);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q     <= 1'b0;
            wr_reg_id_q <= '0;
            wr_data_q   <= '0;
            wr_grant_q  <= '0;
            last_grant  <= IW'(NUM_REQ - 1);
        end else if (win_found) begin
            // A reg-0 entry still consumes its slot, just without a write.
            wr_en_q     <= (head[win_idx].reg_id != reg_id_t'(ZERO_REG));
            wr_reg_id_q <= head[win_idx].reg_id;
            wr_data_q   <= head[win_idx].data;
            wr_grant_q  <= NUM_REQ'(1) << win_idx;
            last_grant  <= win_idx;
        end else begin
            wr_en_q    <= 1'b0;
            wr_grant_q <= '0;
        end
    end

    always_comb begin
        busy_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                if (ent_vld[i][k]) begin
                    busy_c = busy_c | onehot_reg(ent_id[i][k]);
                end
            end
        end
        if (wr_en_q) begin
            busy_c = busy_c | onehot_reg(wr_reg_id_q);
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_reg_id = wr_reg_id_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_grant  = wr_grant_q;
    assign bus.busy      = busy_c;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed testbench for rf_write_arbiter.
// Scenario tasks run in sequence and count checks/errors.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    localparam int NR = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    rf_write_arbiter_if #(.NUM_REQ(NR)) bus ();

    rf_write_arbiter #(
        .NUM_REQ    (NR),
        .FIFO_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v,
                         input reg_id_t id, input data_t d);
        bus.req_valid[i] = v;
        bus.req_reg_id[i*REG_ID_W +: REG_ID_W] = id;
        bus.req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic idle();
        for (int i = 0; i < NR; i++) drive(i, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #2;
        checks++;
        if (bus.wr_en !== 1'b0 || bus.wr_grant !== 2'b00) begin
            errors++;
            $display("FAIL reset_wr: wr_en=%b grant=%b want 0/00",
                     bus.wr_en, bus.wr_grant);
        end
        checks++;
        if (bus.wr_reg_id !== 4'd0 || bus.wr_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_bus: reg=%h data=%h want 0/0",
                     bus.wr_reg_id, bus.wr_data);
        end
        checks++;
        if (bus.busy !== 16'h0 || bus.req_ready !== 2'b11) begin
            errors++;
            $display("FAIL reset_busy: busy=%h ready=%b want 0/11",
                     bus.busy, bus.req_ready);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        drive(0, 1'b1, 4'd3, 16'hABCD);
        tick();
        idle();
        checks++;
        if (bus.busy !== 16'h0008 || bus.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL single_queued: busy=%h wr_en=%b want 0008/0",
                     bus.busy, bus.wr_en);
        end
        tick();
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_reg_id !== 4'd3 ||
            bus.wr_data !== 16'hABCD || bus.wr_grant !== 2'b01) begin
            errors++;
            $display("FAIL single_write: en=%b reg=%h data=%h g=%b want 1/3/abcd/01",
                     bus.wr_en, bus.wr_reg_id, bus.wr_data, bus.wr_grant);
        end
        checks++;
        if (bus.busy !== 16'h0008) begin
            errors++;
            $display("FAIL single_busy_fly: busy=%h want 0008", bus.busy);
        end
        tick();
        checks++;
        if (bus.wr_en !== 1'b0 || bus.wr_grant !== 2'b00 ||
            bus.busy !== 16'h0 || bus.wr_reg_id !== 4'd3) begin
            errors++;
            $display("FAIL single_done: en=%b g=%b busy=%h reg=%h want 0/00/0/3",
                     bus.wr_en, bus.wr_grant, bus.busy, bus.wr_reg_id);
        end
    endtask

    task automatic test_both();
        int ai[NR];
        logic acc[NR];
        int exp_regs[8];
        int nw;
        int first;
        int last;
        exp_regs = '{1, 5, 2, 6, 3, 7, 4, 8};
        ai = '{0, 0};
        nw = 0;
        first = -1;
        last = -1;
        do_reset();
        for (int cyc = 0; cyc < 20; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (ai[i] < 4) begin
                    drive(i, 1'b1, reg_id_t'(i*4 + ai[i] + 1),
                          data_t'((i*4 + ai[i] + 1) * 16'h1111));
                end else begin
                    drive(i, 1'b0, '0, '0);
                end
                acc[i] = bus.req_valid[i] && bus.req_ready[i];
            end
            tick();
            for (int i = 0; i < NR; i++) if (acc[i]) ai[i]++;
            if (bus.wr_en) begin
                checks++;
                if (nw >= 8) begin
                    errors++;
                    $display("FAIL both_extra: write reg=%h beyond 8",
                             bus.wr_reg_id);
                end else if (bus.wr_reg_id !== reg_id_t'(exp_regs[nw]) ||
                             bus.wr_data !== data_t'(exp_regs[nw] * 16'h1111)) begin
                    errors++;
                    $display("FAIL both_order[%0d]: reg=%h data=%h want %h/%h",
                             nw, bus.wr_reg_id, bus.wr_data, exp_regs[nw],
                             data_t'(exp_regs[nw] * 16'h1111));
                end
                nw++;
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        idle();
        checks++;
        if (nw != 8 || last - first != 7) begin
            errors++;
            $display("FAIL both_count: writes=%0d span=%0d want 8/7",
                     nw, last - first);
        end
    endtask

    task automatic test_fair();
        int cnt1;
        logic acc1;
        cnt1 = 0;
        do_reset();
        for (int cyc = 0; cyc < 14; cyc++) begin
            drive(0, 1'b1, 4'd1, data_t'(cyc));
            drive(1, 1'b1, 4'd9, data_t'(cyc + 16'h100));
            checks++;
            if (bus.req_ready[1] !== (cnt1 != 2)) begin
                errors++;
                $display("FAIL fair_ready[%0d]: ready1=%b count=%0d",
                         cyc, bus.req_ready[1], cnt1);
            end
            acc1 = bus.req_ready[1];
            tick();
            cnt1 = cnt1 + int'(acc1) - int'(bus.wr_grant[1]);
            if (cyc >= 1) begin
                checks++;
                if (bus.wr_grant !== ((cyc % 2 == 1) ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("FAIL fair_grant[%0d]: grant=%b want %b", cyc,
                             bus.wr_grant, (cyc % 2 == 1) ? 2'b01 : 2'b10);
                end
            end
        end
        idle();
        for (int k = 0; k < 6; k++) tick();
    endtask

    task automatic test_reg0();
        do_reset();
        drive(0, 1'b1, 4'd0, 16'hFFFF);
        tick();
        checks++;
        if (bus.busy !== 16'h0 || bus.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reg0_queued: busy=%h en=%b want 0/0",
                     bus.busy, bus.wr_en);
        end
        drive(0, 1'b1, 4'd2, 16'h0005);
        tick();
        idle();
        checks++;
        if (bus.wr_en !== 1'b0 || bus.wr_grant !== 2'b01 ||
            bus.busy !== 16'h0004) begin
            errors++;
            $display("FAIL reg0_slot: en=%b g=%b busy=%h want 0/01/0004",
                     bus.wr_en, bus.wr_grant, bus.busy);
        end
        tick();
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_reg_id !== 4'd2 ||
            bus.wr_data !== 16'h0005 || bus.wr_grant !== 2'b01 ||
            bus.busy !== 16'h0004) begin
            errors++;
            $display("FAIL reg0_next: en=%b reg=%h data=%h g=%b busy=%h",
                     bus.wr_en, bus.wr_reg_id, bus.wr_data,
                     bus.wr_grant, bus.busy);
        end
        tick();
        checks++;
        if (bus.busy !== 16'h0) begin
            errors++;
            $display("FAIL reg0_idle: busy=%h want 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(0, 1'b1, 4'd1, 16'h0001);
        drive(1, 1'b1, 4'd5, 16'h0005);
        tick();
        drive(0, 1'b1, 4'd2, 16'h0002);
        drive(1, 1'b1, 4'd6, 16'h0006);
        tick();
        idle();
        tick();
        checks++;
        if (bus.wr_en !== 1'b1 || bus.busy === 16'h0) begin
            errors++;
            $display("FAIL mid_pre: en=%b busy=%h want 1/nonzero",
                     bus.wr_en, bus.busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.wr_en !== 1'b0 || bus.busy !== 16'h0 ||
            bus.req_ready !== 2'b11 || bus.wr_grant !== 2'b00) begin
            errors++;
            $display("FAIL mid_rst: en=%b busy=%h rdy=%b g=%b want 0/0/11/00",
                     bus.wr_en, bus.busy, bus.req_ready, bus.wr_grant);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bus.wr_en !== 1'b0 || bus.busy !== 16'h0) begin
            errors++;
            $display("FAIL mid_after: en=%b busy=%h want 0/0",
                     bus.wr_en, bus.busy);
        end
        drive(0, 1'b1, 4'd3, 16'h0033);
        drive(1, 1'b1, 4'd7, 16'h0077);
        tick();
        idle();
        tick();
        checks++;
        if (bus.wr_grant !== 2'b01 || bus.wr_reg_id !== 4'd3) begin
            errors++;
            $display("FAIL mid_first: g=%b reg=%h want 01/3",
                     bus.wr_grant, bus.wr_reg_id);
        end
        tick();
        tick();
    endtask

    task automatic test_full_pop();
        wr_entry_t q0[$];
        wr_entry_t q1[$];
        wr_entry_t e;
        wr_entry_t ent[NR];
        logic acc[NR];
        int ai[NR];
        logic refused;
        logic seen;
        int nw;
        ai = '{0, 0};
        seen = 1'b0;
        nw = 0;
        do_reset();
        for (int cyc = 0; cyc < 40; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                ent[i].reg_id = reg_id_t'(i*8 + ai[i] + 1);
                ent[i].data = data_t'(16'h1000 * (i + 1) + ai[i]);
                drive(i, ai[i] < 6, ent[i].reg_id, ent[i].data);
                acc[i] = bus.req_valid[i] && bus.req_ready[i];
            end
            refused = bus.req_valid[0] && !bus.req_ready[0];
            tick();
            if (refused && bus.wr_grant[0]) seen = 1'b1;
            if (acc[0]) begin q0.push_back(ent[0]); ai[0]++; end
            if (acc[1]) begin q1.push_back(ent[1]); ai[1]++; end
            if (bus.wr_en) begin
                checks++;
                nw++;
                if (bus.wr_grant == 2'b01 && q0.size() > 0) begin
                    e = q0.pop_front();
                end else if (bus.wr_grant == 2'b10 && q1.size() > 0) begin
                    e = q1.pop_front();
                end else begin
                    e = '0;
                end
                if (bus.wr_reg_id !== e.reg_id || bus.wr_data !== e.data) begin
                    errors++;
                    $display("FAIL sb_entry: g=%b reg=%h data=%h want %h/%h",
                             bus.wr_grant, bus.wr_reg_id, bus.wr_data,
                             e.reg_id, e.data);
                end
            end
        end
        idle();
        checks++;
        if (q0.size() != 0 || q1.size() != 0 || nw != 12 ||
            ai[0] != 6 || ai[1] != 6) begin
            errors++;
            $display("FAIL sb_drain: left=%0d/%0d writes=%0d want 0/0/12",
                     q0.size(), q1.size(), nw);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL full_pop: refused push during pop not observed got %b want 1",
                     seen);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_fair();
        test_reg0();
        test_reset_mid();
        test_full_pop();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
